// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared load/store encodings, FSM states and line geometry.
package data_cache_pkg;
    localparam int OFFSET_W = 4;
    localparam int LINE_W = 128;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_op_e;
    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10
    } store_op_e;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_e;
endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: block-transfer bus between the cache (master) and main memory (slave).
interface data_cache_if;
    import data_cache_pkg::*;
    logic              mem_read;
    logic              mem_write;
    logic [27:0]       mem_address;
    logic [LINE_W-1:0] mem_writedata;
    logic [LINE_W-1:0] mem_readdata;
    logic              mem_busywait;
    modport master (output mem_read, mem_write, mem_address, mem_writedata,
                    input mem_readdata, mem_busywait);
    modport slave (input mem_read, mem_write, mem_address, mem_writedata,
                   output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_load_extend.sv
// dcache_load_extend: picks the byte/half/word lane from a line and sign/zero extends it.
module dcache_load_extend
    import data_cache_pkg::*;
(
    input  logic [LINE_W-1:0]   line,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [2:0]          funct3,
    output logic [31:0]         data
);
    logic [31:0] w32;
    logic [15:0] h16;
    logic [7:0]  b8;
    always_comb begin
        w32 = line[{offset[3:2], 5'd0} +: 32];
        h16 = w32[{offset[1], 4'd0} +: 16];
        b8 = w32[{offset[1:0], 3'd0} +: 8];
        data = funct3 == LB  ? {{24{b8[7]}}, b8} :
               funct3 == LBU ? {24'd0, b8} :
               funct3 == LH  ? {{16{h16[15]}}, h16} :
               funct3 == LHU ? {16'd0, h16} : w32;
    end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back, write-allocate data cache with 16-byte lines.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  memReadEn,
    input  logic [2:0]  memWriteEn,
    input  logic [31:0] DATA_CACHE_ADDR,
    input  logic [31:0] DATA_CACHE_DATA,
    output logic [31:0] DATA_CACHE_READ_DATA,
    output logic        DATA_CACHE_BUSY_WAIT,
    data_cache_if.master mem
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    logic [LINE_W-1:0] data_arr [LINES];
    logic [TAG_W-1:0]  tag_arr [LINES];
    logic [LINES-1:0]  valid, dirty;
    state_e state, next;

    logic [OFFSET_W-1:0] offset;
    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic rd_en, wr_en, hit;
    logic [LINE_W-1:0] merged;
    logic [31:0] load_data;

    assign offset = DATA_CACHE_ADDR[OFFSET_W-1:0];
    assign index = DATA_CACHE_ADDR[OFFSET_W+IDX_W-1:OFFSET_W];
    assign tag = DATA_CACHE_ADDR[31:OFFSET_W+IDX_W];
    // A simultaneous read and write is a write; the read is dropped.
    assign wr_en = memWriteEn[2];
    assign rd_en = memReadEn[3] & ~wr_en;
    assign hit = valid[index] && tag_arr[index] == tag;

    dcache_load_extend u_ext (
        .line(data_arr[index]),
        .offset(offset),
        .funct3(memReadEn[2:0]),
        .data(load_data)
    );

    assign DATA_CACHE_READ_DATA = (rd_en && hit) ? load_data : 32'd0;
    assign DATA_CACHE_BUSY_WAIT = ((rd_en || wr_en) && !hit) || state != IDLE;

    always_comb begin
        merged = data_arr[index];
        if (memWriteEn[1:0] == SB)
            merged[{offset, 3'd0} +: 8] = DATA_CACHE_DATA[7:0];
        else if (memWriteEn[1:0] == SH)
            merged[{offset[3:1], 4'd0} +: 16] = DATA_CACHE_DATA[15:0];
        else if (memWriteEn[1:0] == SW)
            merged[{offset[3:2], 5'd0} +: 32] = DATA_CACHE_DATA;
    end

    always_comb begin
        next = state;
        if (state == IDLE)
            next = ((rd_en || wr_en) && !hit) ? ((valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE) : IDLE;
        else if (state == WRITEBACK)
            next = mem.mem_busywait ? WRITEBACK : ALLOCATE;
        else if (state == ALLOCATE)
            next = mem.mem_busywait ? ALLOCATE : UPDATE;
        else
            next = IDLE;
        mem.mem_write = state == WRITEBACK;
        mem.mem_read = state == ALLOCATE;
        mem.mem_address = state == WRITEBACK ? {tag_arr[index], index} : DATA_CACHE_ADDR[31:4];
        mem.mem_writedata = data_arr[index];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next;
            if (state == UPDATE) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (state == IDLE && wr_en && hit) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // Data and tag arrays are left uninitialised; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (!RESET && state == UPDATE) begin
            data_arr[index] <= mem.mem_readdata;
            tag_arr[index] <= tag;
        end else if (!RESET && state == IDLE && wr_en && hit) begin
            data_arr[index] <= merged;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed checks of hits, misses, write-back, stalls and reset.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rd = '0;
    logic [2:0]  wr = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    int n_chk = 0;
    int n_err = 0;

    data_cache_if bus ();

    data_cache #(.LINES(8)) dut (
        .CLK(clk),
        .RESET(rst),
        .memReadEn(rd),
        .memWriteEn(wr),
        .DATA_CACHE_ADDR(addr),
        .DATA_CACHE_DATA(wdata),
        .DATA_CACHE_READ_DATA(rdata),
        .DATA_CACHE_BUSY_WAIT(busy),
        .mem(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rd = r;
        wr = w;
        addr = a;
        wdata = d;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bus.mem_busywait = 1'b1;
        bus.mem_readdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        // cold miss on LW 0x40
        req(4'b1010, 3'b000, 32'h40, 32'd0);
        check("miss_busy", {31'd0, busy}, 32'd1);
        check("miss_idle_read", {31'd0, bus.mem_read}, 32'd0);
        tick();
        check("alloc_read", {31'd0, bus.mem_read}, 32'd1);
        check("alloc_write", {31'd0, bus.mem_write}, 32'd0);
        check("alloc_addr", {4'd0, bus.mem_address}, 32'h4);
        bus.mem_readdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        bus.mem_busywait = 1'b0;
        tick();
        bus.mem_busywait = 1'b1;
        check("update_busy", {31'd0, busy}, 32'd1);
        check("update_read", {31'd0, bus.mem_read}, 32'd0);
        tick();
        check("fill_busy", {31'd0, busy}, 32'd0);
        check("fill_lw", rdata, 32'hDEADBEEF);
        req(4'b1010, 3'b000, 32'h44, 32'd0);
        check("fill_lw_w1", rdata, 32'h11111111);
        // store byte hit, then loads of that lane
        req(4'b0000, 3'b100, 32'h41, 32'h80);
        check("sb_busy", {31'd0, busy}, 32'd0);
        req(4'b1000, 3'b000, 32'h41, 32'd0);
        check("lb", rdata, 32'hFFFFFF80);
        req(4'b1100, 3'b000, 32'h41, 32'd0);
        check("lbu", rdata, 32'h00000080);
        req(4'b1010, 3'b000, 32'h43, 32'd0);
        check("lw_merged", rdata, 32'hDEAD80EF);
        // conflict miss on a dirty line
        req(4'b1010, 3'b000, 32'hC0, 32'd0);
        check("conf_busy", {31'd0, busy}, 32'd1);
        tick();
        check("wb_write", {31'd0, bus.mem_write}, 32'd1);
        check("wb_read", {31'd0, bus.mem_read}, 32'd0);
        check("wb_addr", {4'd0, bus.mem_address}, 32'h4);
        check("wb_data", bus.mem_writedata[31:0], 32'hDEAD80EF);
        bus.mem_busywait = 1'b0;
        tick();
        bus.mem_busywait = 1'b1;
        check("alloc2_write", {31'd0, bus.mem_write}, 32'd0);
        check("alloc2_read", {31'd0, bus.mem_read}, 32'd1);
        check("alloc2_addr", {4'd0, bus.mem_address}, 32'hC);
        // memory holds busywait high for several cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_read", {31'd0, bus.mem_read}, 32'd1);
            check("stall_busy", {31'd0, busy}, 32'd1);
            check("stall_addr", {4'd0, bus.mem_address}, 32'hC);
        end
        bus.mem_readdata = {32'h77777777, 32'h66666666, 32'h55555555, 32'hCAFEF00D};
        bus.mem_busywait = 1'b0;
        tick();
        bus.mem_busywait = 1'b1;
        tick();
        check("fill2_busy", {31'd0, busy}, 32'd0);
        check("fill2_lw", rdata, 32'hCAFEF00D);
        req(4'b1010, 3'b000, 32'hCC, 32'd0);
        check("fill2_w3", rdata, 32'h77777777);
        // halfword stores and loads
        req(4'b0000, 3'b101, 32'hC2, 32'h1234);
        check("sh_busy", {31'd0, busy}, 32'd0);
        req(4'b1001, 3'b000, 32'hC2, 32'd0);
        check("lh_pos", rdata, 32'h00001234);
        req(4'b0000, 3'b101, 32'hC3, 32'hFFFF8001);
        req(4'b1001, 3'b000, 32'hC3, 32'd0);
        check("lh_neg", rdata, 32'hFFFF8001);
        req(4'b1101, 3'b000, 32'hC2, 32'd0);
        check("lhu", rdata, 32'h00008001);
        req(4'b1010, 3'b000, 32'hC0, 32'd0);
        check("lw_after_sh", rdata, 32'h8001F00D);
        // read and write together act as a write
        req(4'b1010, 3'b100, 32'hC3, 32'h55);
        check("rw_rdata", rdata, 32'd0);
        check("rw_busy", {31'd0, busy}, 32'd0);
        req(4'b1010, 3'b000, 32'hC0, 32'd0);
        check("rw_merged", rdata, 32'h5501F00D);
        // idle cycle changes nothing
        req(4'b0000, 3'b000, 32'h40, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rdata", rdata, 32'd0);
        // reset in the middle of a write-back
        req(4'b1010, 3'b000, 32'h40, 32'd0);
        tick();
        check("wb2_write", {31'd0, bus.mem_write}, 32'd1);
        check("wb2_addr", {4'd0, bus.mem_address}, 32'hC);
        check("wb2_data", bus.mem_writedata[31:0], 32'h5501F00D);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wb_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_wb_read", {31'd0, bus.mem_read}, 32'd0);
        check("rst_wb_busy", {31'd0, busy}, 32'd1);
        check("rst_wb_rdata", rdata, 32'd0);
        tick();
        check("rst_realloc_read", {31'd0, bus.mem_read}, 32'd1);
        check("rst_realloc_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_realloc_addr", {4'd0, bus.mem_address}, 32'h4);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
